mdu: RTL and testbench

Multi-cycle multiply/divide unit for the pipelined MIPS core, sitting in EX beside the combinational ALU. It takes an operation code and two operands from the ID/EX pipeline registers and raises `Busy` while it computes. It writes 64-bit products or quotient/remainder pairs into the architectural HI/LO registers. The hazard unit stalls any later MDU instruction (including MFHI/MFLO) while `Start | Busy`.

---
 rtl/mdu_pkg.sv | 45 ++++
 rtl/mdu.sv | 143 ++++++++++++++
 tb/tb_mdu.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: opcodes, FSM states and the
// sign-corrected divide helper used on the latched operands.
package mdu_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } mdu_state_e;

  // Returns {remainder, quotient}. Signed division is done on magnitudes so
  // 0x80000000 / -1 falls out as 0x80000000 rem 0 without a special case.
  function automatic logic [63:0] div_rem(input word_t a, input word_t b,
                                          input logic is_signed);
    word_t mag_a, mag_b, quo, rem;
    logic  neg_q, neg_r;
    if (is_signed) begin
      neg_q = a[31] ^ b[31];
      neg_r = a[31];
      mag_a = a[31] ? (32'd0 - a) : a;
      mag_b = b[31] ? (32'd0 - b) : b;
    end else begin
      neg_q = 1'b0;
      neg_r = 1'b0;
      mag_a = a;
      mag_b = b;
    end
    quo = mag_a / mag_b;
    rem = mag_a % mag_b;
    return {(neg_r ? (32'd0 - rem) : rem), (neg_q ? (32'd0 - quo) : quo)};
  endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit: one FSM with a down-counter, results
// taken from operands latched at Start and written to HI/LO when cnt hits 0.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

  mdu_state_e       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [3:0]       op_r, op_s;
  word_t            a_r, a_s, b_r, b_s;
  word_t            hi_r, hi_s, lo_r, lo_s;
  logic             busy_r, busy_s;
  logic [63:0]      ext_a_s, ext_b_s, prod_s, divres_s;

  // Datapath on latched operands: sign- or zero-extended product and divide.
  always_comb begin
    if (op_r == MDU_MULT) begin
      ext_a_s = {{32{a_r[31]}}, a_r};
      ext_b_s = {{32{b_r[31]}}, b_r};
    end else begin
      ext_a_s = {32'd0, a_r};
      ext_b_s = {32'd0, b_r};
    end
    prod_s   = ext_a_s * ext_b_s;
    divres_s = div_rem(a_r, b_r, op_r == MDU_DIV);
  end

  // Next-state, counter, operand latch and HI/LO write-back.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    op_s    = op_r;
    a_s     = a_r;
    b_s     = b_r;
    hi_s    = hi_r;
    lo_s    = lo_r;
    case (state_r)
      S_IDLE: begin
        if (Start) begin
          case (MDUOp)
            MDU_MULT, MDU_MULTU: begin
              state_s = S_MUL;
              cnt_s   = CNT_MULT;
              op_s    = MDUOp;
              a_s     = SrcA;
              b_s     = SrcB;
            end
            MDU_DIV, MDU_DIVU: begin
              state_s = S_DIV;
              cnt_s   = CNT_DIV;
              op_s    = MDUOp;
              a_s     = SrcA;
              b_s     = SrcB;
            end
            MDU_MTHI: hi_s = SrcA;
            MDU_MTLO: lo_s = SrcA;
            default:  ;
          endcase
        end else begin
          state_s = S_IDLE;
        end
      end
      S_MUL: begin
        if (cnt_r <= CNT_ONE) begin
          state_s = S_IDLE;
          cnt_s   = '0;
          hi_s    = prod_s[63:32];
          lo_s    = prod_s[31:0];
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      S_DIV: begin
        if (cnt_r <= CNT_ONE) begin
          state_s = S_IDLE;
          cnt_s   = '0;
          // A zero divisor still burns the full latency but leaves HI/LO alone.
          if (b_r != 32'd0) begin
            hi_s = divres_s[63:32];
            lo_s = divres_s[31:0];
          end else begin
            hi_s = hi_r;
            lo_s = lo_r;
          end
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = '0;
      end
    endcase
    busy_s = (state_s != S_IDLE);
  end

  // State registers; reset wins over any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      op_r    <= 4'd0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      op_r    <= op_s;
      a_r     <= a_s;
      b_r     <= b_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
      busy_r  <= busy_s;
    end
  end

  assign Busy = busy_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: expected HI/LO/latency are queued per
// operation and compared when Busy drops.
module tb_mdu;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  MDUOp;
  logic [31:0] SrcA, SrcB;
  logic        Busy;
  logic [31:0] HI, LO;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_hi, model_lo;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp),
    .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // mode 0: quiet; mode 1: scramble operands while busy;
  // mode 2: fire DIV then MTHI 0x1234 while busy (must be ignored).
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int ecyc,
                        input int mode, input string name);
    exp_t e;
    int   cyc;
    logic held;
    e.hi = ehi; e.lo = elo; e.cycles = ecyc;
    sb.push_back(e);
    Start = 1'b1; MDUOp = op; SrcA = a; SrcB = b;
    @(negedge clk);
    Start = 1'b0; MDUOp = OP_NONE;
    cyc  = 0;
    held = 1'b1;
    while (Busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (HI !== model_hi || LO !== model_lo) held = 1'b0;
      if (mode == 1) begin
        SrcA = $urandom; SrcB = $urandom;
      end
      if (mode == 2 && cyc == 1) begin
        Start = 1'b1; MDUOp = OP_DIV; SrcA = 32'd100; SrcB = 32'd3;
      end else if (mode == 2 && cyc == 2) begin
        Start = 1'b1; MDUOp = OP_MTHI; SrcA = 32'h0000_1234;
      end else begin
        Start = 1'b0; MDUOp = OP_NONE;
      end
      @(negedge clk);
    end
    Start = 1'b0; MDUOp = OP_NONE;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: no expectation queued", name);
    end else begin
      e = sb.pop_front();
      if (cyc !== e.cycles) begin
        errors++;
        $display("FAIL %s busy_cycles: got %0d expected %0d", name, cyc, e.cycles);
      end
      checks++;
      if (HI !== e.hi) begin
        errors++;
        $display("FAIL %s HI: got %h expected %h", name, HI, e.hi);
      end
      checks++;
      if (LO !== e.lo) begin
        errors++;
        $display("FAIL %s LO: got %h expected %h", name, LO, e.lo);
      end
      if (e.cycles > 0) begin
        checks++;
        if (held !== 1'b1) begin
          errors++;
          $display("FAIL %s hold_during_busy: HI/LO changed before completion, expected %h/%h",
                   name, model_hi, model_lo);
        end
      end
      model_hi = e.hi;
      model_lo = e.lo;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; Start = 1'b0; MDUOp = OP_NONE; SrcA = 32'd0; SrcB = 32'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: Busy=%b HI=%h LO=%h expected 0/0/0", Busy, HI, LO);
    end
    reset = 1'b0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 0, "mult_neg2x3");
  endtask

  task automatic test_multu_scramble();
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5, 1, "multu_max");
  endtask

  task automatic test_div();
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 0, "div_neg7by2");
    run_op(OP_DIVU, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, 10, 0, "divu_by2");
  endtask

  task automatic test_mt_and_div_edges();
    run_op(OP_MTHI, 32'h0000_0011, 32'h0, 32'h0000_0011, 32'h7FFF_FFFC, 0, 0, "mthi");
    run_op(OP_MTLO, 32'h0000_0022, 32'h0, 32'h0000_0011, 32'h0000_0022, 0, 0, "mtlo");
    run_op(OP_DIV, 32'h0000_0064, 32'h0000_0000, 32'h0000_0011, 32'h0000_0022, 10, 0, "div_by0");
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10, 0, "div_ovf");
  endtask

  task automatic test_ignore_busy();
    run_op(OP_MULT, 32'h0000_0007, 32'h0000_0006, 32'h0000_0000, 32'h0000_002A, 5, 2, "ignore_busy");
  endtask

  task automatic test_back_to_back();
    // Issued immediately: Start is sampled on the edge right after Busy fell.
    run_op(OP_MULT, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5, 0, "b2b_mult");
    run_op(OP_MULTU, 32'h0000_0003, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 5, 0, "b2b_multu");
  endtask

  task automatic test_reset_midop();
    int bad;
    run_op(OP_MTHI, 32'h0000_00AA, 32'h0, 32'h0000_00AA, 32'h8000_0000, 0, 0, "pre_mthi");
    run_op(OP_MTLO, 32'h0000_00BB, 32'h0, 32'h0000_00AA, 32'h0000_00BB, 0, 0, "pre_mtlo");
    Start = 1'b1; MDUOp = OP_DIV; SrcA = 32'd100; SrcB = 32'd7;
    @(negedge clk);
    Start = 1'b0; MDUOp = OP_NONE;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (Busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_midop_busy: Busy=%b expected 1 on 3rd busy cycle", Busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++;
      $display("FAIL reset_midop: Busy=%b HI=%h LO=%h expected 0/0/0", Busy, HI, LO);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_no_stale_writeback: %0d bad cycles, expected 0 (Busy=%b HI=%h LO=%h)",
               bad, Busy, HI, LO);
    end
    model_hi = 32'd0;
    model_lo = 32'd0;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu_scramble();
    test_div();
    test_mt_and_div_edges();
    test_ignore_busy();
    test_back_to_back();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
